// File: rtl/adpcmb_nibble_dec.sv
// ADPCM-B (delta-T) nibble decoder: a five-state step/accumulate sequencer that
// turns one 4-bit code into a level-scaled, registered signed 16-bit PCM sample.
module adpcmb_nibble_dec #(
    parameter int STEP_MIN = 127,
    parameter int STEP_MAX = 24576
) (
    input  logic        rst_n,
    input  logic        clk,
    input  logic        cen,
    input  logic        adv,
    input  logic        clr_dec,
    input  logic        nibble_sel,
    input  logic [7:0]  data,
    input  logic [7:0]  level,
    output logic [15:0] pcm,
    output logic        pcm_valid,
    output logic        busy,
    output logic        ovr,
    output logic [2:0]  dbg_state
);

    // Handshake: a trigger (cen & adv & !clr_dec) is accepted only in IDLE; pcm_valid
    // is a single-clk strobe qualifying pcm, and there is no back-pressure.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELTA = 3'd1,
        ACC   = 3'd2,
        STEP  = 3'd3,
        VOL   = 3'd4
    } state_t;

    localparam logic [14:0] STEP_MIN_C = 15'(STEP_MIN);
    localparam logic [14:0] STEP_MAX_C = 15'(STEP_MAX);
    localparam logic [16:0] STEP_MIN_W = 17'(STEP_MIN);
    localparam logic [16:0] STEP_MAX_W = 17'(STEP_MAX);

    state_t             state_q, state_d;
    logic signed [15:0] acc_q, acc_d;
    logic [14:0]        step_q, step_d;
    logic [3:0]         n_q, n_d;
    logic [7:0]         lvl_q, lvl_d;
    logic [15:0]        delta_q, delta_d;
    logic [15:0]        pcm_q, pcm_d;
    logic               pcm_valid_q, pcm_valid_d;
    logic               ovr_q, ovr_d;

    logic               trigger;
    logic [18:0]        delta_prod;
    logic signed [17:0] acc_sum;
    logic [7:0]         step_mul;
    logic [22:0]        step_prod;
    logic [16:0]        step_scaled;
    logic signed [24:0] acc_x, gain_x, vol_prod;

    always_comb begin
        unique case (n_q[2:0])
            3'd4:    step_mul = 8'd77;
            3'd5:    step_mul = 8'd102;
            3'd6:    step_mul = 8'd128;
            3'd7:    step_mul = 8'd153;
            default: step_mul = 8'd57;
        endcase
    end

    // Datapath products; each is consumed only in its own sequencer state.
    always_comb begin
        delta_prod  = 19'({n_q[2:0], 1'b1}) * 19'(step_q);
        acc_sum     = n_q[3] ? ({{2{acc_q[15]}}, acc_q} - {2'b00, delta_q})
                             : ({{2{acc_q[15]}}, acc_q} + {2'b00, delta_q});
        step_prod   = 23'(step_q) * 23'(step_mul);
        step_scaled = 17'(step_prod >> 6);
        acc_x       = {{9{acc_q[15]}}, acc_q};
        gain_x      = {16'd0, ({1'b0, lvl_q} + 9'd1)};
        vol_prod    = acc_x * gain_x;
    end

    assign trigger = cen & adv & ~clr_dec;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        step_d      = step_q;
        n_d         = n_q;
        lvl_d       = lvl_q;
        delta_d     = delta_q;
        pcm_d       = pcm_q;
        pcm_valid_d = 1'b0;
        ovr_d       = ovr_q;
        if (clr_dec) begin
            state_d = IDLE;
            acc_d   = '0;
            step_d  = STEP_MIN_C;
            pcm_d   = '0;
            ovr_d   = 1'b0;
        end else begin
            if (trigger && state_q != IDLE) begin
                ovr_d = 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (trigger) begin
                        n_d     = nibble_sel ? data[3:0] : data[7:4];
                        lvl_d   = level;
                        state_d = DELTA;
                    end
                end
                DELTA: begin
                    delta_d = 16'(delta_prod >> 3);
                    state_d = ACC;
                end
                ACC: begin
                    if (acc_sum > 18'sd32767) begin
                        acc_d = 16'sh7fff;
                    end else if (acc_sum < -18'sd32768) begin
                        acc_d = 16'sh8000;
                    end else begin
                        acc_d = acc_sum[15:0];
                    end
                    state_d = STEP;
                end
                STEP: begin
                    if (step_scaled < STEP_MIN_W) begin
                        step_d = STEP_MIN_C;
                    end else if (step_scaled > STEP_MAX_W) begin
                        step_d = STEP_MAX_C;
                    end else begin
                        step_d = step_scaled[14:0];
                    end
                    state_d = VOL;
                end
                VOL: begin
                    pcm_d       = 16'(vol_prod >>> 8);
                    pcm_valid_d = 1'b1;
                    state_d     = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            step_q      <= STEP_MIN_C;
            n_q         <= '0;
            lvl_q       <= '0;
            delta_q     <= '0;
            pcm_q       <= '0;
            pcm_valid_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            step_q      <= step_d;
            n_q         <= n_d;
            lvl_q       <= lvl_d;
            delta_q     <= delta_d;
            pcm_q       <= pcm_d;
            pcm_valid_q <= pcm_valid_d;
            ovr_q       <= ovr_d;
        end
    end

    assign pcm       = pcm_q;
    assign pcm_valid = pcm_valid_q;
    assign busy      = (state_q != IDLE);
    assign ovr       = ovr_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_adpcmb_nibble_dec.sv
// Directed bench for adpcmb_nibble_dec: hand-computed PCM values for single codes,
// step clamping, saturation, overrun, mid-sequence clear and asynchronous reset.
module tb_adpcmb_nibble_dec;

    logic        clk = 1'b0;
    logic        rst_n, cen, adv, clr_dec, nibble_sel;
    logic [7:0]  data, level;
    logic [15:0] pcm;
    logic        pcm_valid, busy, ovr;
    logic [2:0]  dbg_state;

    int n_pass  = 0;
    int n_total = 0;
    logic [15:0] exp_q[$];

    adpcmb_nibble_dec dut (
        .rst_n      (rst_n),
        .clk        (clk),
        .cen        (cen),
        .adv        (adv),
        .clr_dec    (clr_dec),
        .nibble_sel (nibble_sel),
        .data       (data),
        .level      (level),
        .pcm        (pcm),
        .pcm_valid  (pcm_valid),
        .busy       (busy),
        .ovr        (ovr),
        .dbg_state  (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic trig(input logic [7:0] dat, input logic sel, input logic [7:0] lvl);
        data       = dat;
        nibble_sel = sel;
        level      = lvl;
        cen        = 1'b1;
        adv        = 1'b1;
        tick();
        cen        = 1'b0;
        adv        = 1'b0;
    endtask

    // Latency counted in clk edges from the trigger being driven; -1 if never seen.
    task automatic wait_valid(output int lat);
        lat = -1;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (pcm_valid) begin
                lat = i + 1;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (pcm_valid) pulses++;
        end
    endtask

    task automatic decode(input logic [7:0] dat, input logic sel, input logic [7:0] lvl,
                          input int exp_pcm, input string tag);
        int lat;
        trig(dat, sel, lvl);
        check({tag, "_busy"}, int'(busy), 1);
        wait_valid(lat);
        check({tag, "_lat"}, lat, 5);
        check(tag, int'($signed(pcm)), exp_pcm);
        tick();
        check({tag, "_pulse"}, int'(pcm_valid), 0);
    endtask

    task automatic clear_dec();
        clr_dec = 1'b1;
        tick();
        clr_dec = 1'b0;
    endtask

    task automatic sat_run(input logic [7:0] dat, input int sign_exp, input int final_exp,
                           input string tag);
        int lat;
        for (int k = 0; k < 30; k++) begin
            trig(dat, 1'b0, 8'hFF);
            wait_valid(lat);
            if (k < 4) check({tag, "_early"}, int'($signed(pcm)), int'($signed(exp_q.pop_front())));
            else       check({tag, "_sign"}, int'(pcm[15]), sign_exp);
            tick(); tick(); tick();
        end
        check({tag, "_final"}, int'($signed(pcm)), final_exp);
        check({tag, "_no_ovr"}, int'(ovr), 0);
    endtask

    initial begin
        int lat, pulses;
        rst_n = 1'b0; cen = 1'b0; adv = 1'b0; clr_dec = 1'b0;
        nibble_sel = 1'b0; data = 8'h00; level = 8'h00;
        #1;
        check("rst_pcm", int'(pcm), 0);
        check("rst_valid", int'(pcm_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_ovr", int'(ovr), 0);
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // nibble 7 from reset, then again to confirm step became 303
        decode(8'h78, 1'b0, 8'hFF, 238, "n7");
        decode(8'h78, 1'b0, 8'hFF, 806, "n7_step303");
        clear_dec();
        check("clr_pcm", int'(pcm), 0);

        // nibble 8: step 113 clamps to 127, so nibble 7 next adds 238
        decode(8'h78, 1'b1, 8'hFF, -15, "n8");
        decode(8'h78, 1'b0, 8'hFF, 223, "clamp127");
        clear_dec();
        decode(8'h78, 1'b1, 8'h7F, -8, "n8_half");
        clear_dec();

        // adv without cen must not start a sequence
        adv = 1'b1;
        tick(); tick();
        adv = 1'b0;
        check("no_cen_busy", int'(busy), 0);

        exp_q.push_back(16'd238);  exp_q.push_back(16'd806);
        exp_q.push_back(16'd2163); exp_q.push_back(16'd5406);
        sat_run(8'h77, 0, 32767, "sat_pos");
        clear_dec();
        exp_q.push_back(-16'sd238);  exp_q.push_back(-16'sd806);
        exp_q.push_back(-16'sd2163); exp_q.push_back(-16'sd5406);
        sat_run(8'hFF, 1, -32768, "sat_neg");
        clear_dec();

        // overrun: second trigger two clk after the first
        trig(8'h78, 1'b0, 8'hFF);
        tick();
        trig(8'h78, 1'b0, 8'hFF);
        check("ovr_set", int'(ovr), 1);
        wait_valid(lat);
        check("ovr_first_pcm", int'($signed(pcm)), 238);
        count_pulses(10, pulses);
        check("ovr_dropped", pulses, 0);
        check("ovr_sticky", int'(ovr), 1);
        clear_dec();
        check("ovr_clr", int'(ovr), 0);
        check("ovr_clr_pcm", int'(pcm), 0);

        // clr_dec during ACC aborts the sequence and resets step/acc
        decode(8'h78, 1'b0, 8'hFF, 238, "pre_abort");
        trig(8'h78, 1'b0, 8'hFF);
        tick();
        check("abort_in_acc", int'(dbg_state), 2);
        clr_dec = 1'b1;
        tick();
        clr_dec = 1'b0;
        check("abort_busy", int'(busy), 0);
        check("abort_pcm", int'(pcm), 0);
        check("abort_valid", int'(pcm_valid), 0);
        count_pulses(8, pulses);
        check("abort_no_pulse", pulses, 0);
        decode(8'h78, 1'b0, 8'hFF, 238, "post_abort");

        // counter off: adv and cen high while clr_dec held
        clr_dec = 1'b1; cen = 1'b1; adv = 1'b1;
        count_pulses(6, pulses);
        check("off_busy", int'(busy), 0);
        check("off_pcm", int'(pcm), 0);
        check("off_pulse", pulses, 0);
        clr_dec = 1'b0; cen = 1'b0; adv = 1'b0;
        tick();

        // asynchronous reset while in STEP, with pcm and ovr non-zero
        decode(8'h78, 1'b0, 8'hFF, 238, "pre_rst");
        trig(8'h78, 1'b0, 8'hFF);
        trig(8'h78, 1'b0, 8'hFF);
        tick();
        check("rst_in_step", int'(dbg_state), 3);
        check("rst_pre_ovr", int'(ovr), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_pcm", int'(pcm), 0);
        check("arst_busy", int'(busy), 0);
        check("arst_ovr", int'(ovr), 0);
        check("arst_valid", int'(pcm_valid), 0);
        check("arst_state", int'(dbg_state), 0);
        tick();
        rst_n = 1'b1;
        tick();
        decode(8'h78, 1'b0, 8'hFF, 238, "post_rst");

        // final report
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/adpcmb_nibble_dec.md
Name: adpcmb_nibble_dec

Overview:
- ADPCM-B (delta-T) nibble decoder. Sits directly downstream of the ADPCM-B address/nibble counter.
- Takes that counter's adv, nibble_sel and clr_dec plus the ROM byte fetched at its address.
- Runs a multi-cycle adaptive step/accumulate sequence, applies a channel level, and presents a registered signed 16-bit PCM sample with a one-cycle valid strobe.

Parameters:
- STEP_MIN, 127: reset and lower clamp of the adaptive step.
- STEP_MAX, 24576: upper clamp of the adaptive step.

Ports:
- rst_n  in  1  asynchronous active-low reset
- clk  in  1  clock (CPU clock)
- cen  in  1  sample-rate enable (55 kHz)
- adv  in  1  advance from counter; qualified by cen
- clr_dec  in  1  decoder clear from counter, level-sensitive
- nibble_sel  in  1  0 = data[7:4], 1 = data[3:0]
- data  in  8  ROM byte at current address
- level  in  8  channel level; gain = (level+1)/256
- pcm  out  16  signed decoded, level-scaled sample
- pcm_valid  out  1  one-clk pulse when pcm updates
- busy  out  1  sequencer not IDLE
- ovr  out  1  sticky overrun flag

Behaviour:
- Reset is asynchronous via rst_n, active-low; clock is clk. Reset values: acc=0, step=STEP_MIN, state=IDLE, pcm=0, pcm_valid=0, busy=0, ovr=0.
- clr_dec (synchronous, highest priority after reset), every clk while high:
  - acc=0, step=STEP_MIN, pcm=0, state=IDLE, pcm_valid=0, ovr=0.
  - Triggers are ignored.
- Trigger = cen & adv & !clr_dec.
  - In IDLE: latch nibble n (4 bits, selected by nibble_sel), latch level, go to DELTA.
  - While busy: trigger is dropped, ovr<=1, running sequence is unaffected.
- States; one clk each, independent of cen:
  - IDLE: wait for trigger.
  - DELTA: d = ((2*n[2:0]+1)*step)>>3, unsigned. 19-bit product, 16-bit result.
  - ACC: s = acc - d if n[3], else acc + d. Computed in 18-bit signed, then saturated to [-32768, 32767] into acc.
  - STEP: step = (step*T[n[2:0]])>>6. T = {57,57,57,57,77,102,128,153}. 22-bit product, clamped to [STEP_MIN, STEP_MAX]. Uses the pre-update step.
  - VOL: pcm = (acc*(level+1))>>>8 (arithmetic shift, floor toward -inf), 25-bit product. pcm_valid=1 for exactly this clk's following cycle. Return to IDLE.
- Latency: pcm/pcm_valid appear 5 clk after the trigger edge.
- busy=1 from DELTA through VOL.
- Integration requirement: cen period >= 6 clk; ovr flags violations.
- Level changes mid-sequence have no effect (latched at trigger).
- Counter-off case: adv stays high with clr_dec=1, so the decoder is held cleared; pcm=0.
- Rounding: all right shifts truncate (floor).

Test Plan:
- Reset, clr_dec=0, level=0xFF, data=0x78, nibble_sel=0, one trigger -> after 5 clk pcm=238, pcm_valid pulse of 1 clk, internal step=303.
- Same reset, data=0x78, nibble_sel=1 (nibble 8) -> pcm=-15 (0xFFF1). Step computes 113 and is clamped to 127. Repeat with level=0x7F -> pcm=-8.
- Saturation: 30 consecutive triggers of nibble 0x7, cen every 8 clk, level=0xFF -> step climbs 127, 303, 724, ... and pins at 24576; acc/pcm pins at 32767 and never wraps negative. Mirror with nibble 0xF -> -32768.
- Overrun: two triggers 2 clk apart -> first completes normally, second ignored, ovr=1. Then assert clr_dec 1 clk -> ovr=0, pcm=0.
- clr_dec mid-sequence: trigger, assert clr_dec in the ACC cycle -> no pcm_valid, busy=0 next clk, pcm=0. Next trigger after release decodes from step=127, acc=0 (nibble 7 gives 238).
- Async reset asserted during STEP -> all outputs to reset values immediately without a clk edge.
